// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory store unit.
package dmem_pkg;

  // RV32I fn3 encodings for loads and stores
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Word address field is wide enough for any RAM size; the top uses its low AW bits
  localparam int unsigned WA_W = 30;

  typedef struct packed {
    logic [WA_W-1:0] addr;
    logic [3:0]      mask;
    logic [31:0]     data;
  } sb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE
  } drain_state_t;

  // Alignment check; reserved fn3 codes count as misaligned
  function automatic logic fn3_misaligned(input logic [2:0] fn3, input logic [1:0] boff);
    case (fn3)
      LB, LBU: fn3_misaligned = 1'b0;
      LH, LHU: fn3_misaligned = boff[0];
      LW:      fn3_misaligned = (boff != 2'b00);
      default: fn3_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular store buffer; exposes entries oldest-first for load forwarding.
module sb_fifo
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  sb_entry_t       push_entry,
  input  logic            pop,
  output sb_entry_t       entries [DEPTH],
  output logic [DEPTH-1:0] valid,
  output logic            full,
  output logic            empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  sb_entry_t       mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == CW'(0));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Age-ordered view: index 0 is the head
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      entries[i] = mem[rd_ptr + PW'(i)];
      valid[i]   = (CW'(i) < count);
    end
  end

endmodule

// File: rtl/dmem_store_unit.sv
// Data memory with store buffer, byte-accurate load forwarding and a drain FSM.
module dmem_store_unit
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  input  logic [2:0]  fn3,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] mem_out,
  output logic        stall,
  output logic        misalign
);

  localparam int unsigned WORDS = 1 << AW;

  logic [31:0]    ram [WORDS];
  logic [AW-1:0]  wa;
  logic [1:0]     boff;
  logic           unused_addr_bits;

  sb_entry_t      push_entry;
  sb_entry_t      entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic           fifo_full;
  logic           fifo_empty;
  logic           enq;

  drain_state_t   state;
  drain_state_t   state_d;
  logic           ram_we;
  logic           pop;
  logic           latch;
  logic [31:0]    rd_word;
  logic [31:0]    wr_word;
  logic [AW-1:0]  head_wa;

  logic [31:0]    merged;
  logic [31:0]    shifted;
  logic [31:0]    ext;

  assign wa               = address[AW+1:2];
  assign boff             = address[1:0];
  assign unused_addr_bits = ^address[31:AW+2];

  assign misalign = (mem_read | mem_write) & fn3_misaligned(fn3, boff);
  assign stall    = mem_write & fifo_full;
  assign enq      = mem_write & ~mem_read & ~misalign & ~stall;

  // Store request to lane-aligned buffer entry
  always_comb begin
    push_entry.addr = WA_W'(wa);
    case (fn3[1:0])
      2'b00: begin
        push_entry.mask = 4'b0001 << boff;
        push_entry.data = {4{wr_data[7:0]}};
      end
      2'b01: begin
        push_entry.mask = boff[1] ? 4'b1100 : 4'b0011;
        push_entry.data = {2{wr_data[15:0]}};
      end
      default: begin
        push_entry.mask = 4'b1111;
        push_entry.data = wr_data;
      end
    endcase
  end

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (enq),
    .push_entry (push_entry),
    .pop        (pop),
    .entries    (entries),
    .valid      (valid),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Load path: RAM word overlaid with pending stores oldest to youngest, then extended
  always_comb begin
    merged = ram[wa];
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid[i] && (entries[i].addr == WA_W'(wa))) begin
        for (int b = 0; b < 4; b++) begin
          if (entries[i].mask[b]) merged[8*b +: 8] = entries[i].data[8*b +: 8];
        end
      end
    end
    shifted = merged >> {boff, 3'b000};
    case (fn3)
      LB:      ext = {{24{shifted[7]}}, shifted[7:0]};
      LH:      ext = {{16{shifted[15]}}, shifted[15:0]};
      LW:      ext = merged;
      LBU:     ext = {24'h0, shifted[7:0]};
      LHU:     ext = {16'h0, shifted[15:0]};
      default: ext = 32'h0;
    endcase
    mem_out = (mem_read & ~misalign) ? ext : 32'h0;
  end

  assign head_wa = entries[0].addr[AW-1:0];

  // Head word merged with the latched RAM word for partial stores
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      wr_word[8*b +: 8] = entries[0].mask[b] ? entries[0].data[8*b +: 8] : rd_word[8*b +: 8];
    end
  end

  // Drain FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Drain FSM next state; a load owns the RAM port and freezes the drain
  always_comb begin
    state_d = state;
    ram_we  = 1'b0;
    pop     = 1'b0;
    latch   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !mem_read) state_d = (entries[0].mask == 4'hF) ? ST_WRITE : ST_READ;
      end
      ST_READ: begin
        if (!mem_read) begin
          latch   = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!mem_read) begin
          ram_we  = 1'b1;
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read-modify-write capture for byte/half stores
  always_ff @(posedge clk) begin
    if (latch) rd_word <= ram[head_wa];
  end

  // RAM write port; suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (ram_we && !reset) ram[head_wa] <= wr_word;
  end

endmodule
